data_sync: RTL and testbench

- Multi-bit bus synchronizer for the destination clock domain of the UART system.
- Sits directly downstream of the reset synchronizer: it is clocked in that domain, and its RST is driven from the synchronized reset (inverted to active-high at the top level).
- Carries a quasi-static bus (e.g. RX data or config word) across domains using a single-bit enable. The enable passes through a flop chain, then an edge detector; the detected edge captures the bus and emits a one-cycle strobe.

---
 rtl/data_sync.sv | 75 +++++++
 tb/tb_data_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_sync.sv
// Multi-bit bus synchronizer: BUS_EN crosses through a flop chain, its rising edge
// captures UNSYNC_BUS and emits a one-cycle ENABLE_PULSE. Optional: DATA_SYNC_GLITCH_FILTER_EN.
module data_sync #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  sync_en;
    logic                  qual_en;
    logic                  pulse_q;
    logic                  rise;
    logic [BUS_WIDTH-1:0]  sync_bus_q;
    logic                  enable_pulse_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], BUS_EN};
        end
    end

    assign sync_en = sync_q[NUM_STAGES-1];

`ifdef DATA_SYNC_GLITCH_FILTER_EN
    logic filt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= sync_en;
        end
    end

    // Two consecutive high samples at the chain output are needed to qualify.
    always_comb begin
        qual_en = sync_en & filt_q;
    end
`else
    always_comb begin
        qual_en = sync_en;
    end
`endif

    always_comb begin
        rise = qual_en & ~pulse_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pulse_q        <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
        end else begin
            pulse_q        <= qual_en;
            enable_pulse_q <= rise;
            if (rise) begin
                sync_bus_q <= UNSYNC_BUS;
            end
        end
    end

    assign SYNC_BUS     = sync_bus_q;
    assign ENABLE_PULSE = enable_pulse_q;

endmodule

// File: tb/tb_data_sync.sv
// Self-checking bench for data_sync: vector table plus hand-written multi-cycle sequences.
module tb_data_sync;

    localparam int unsigned NUM_STAGES = 2;
    localparam int unsigned BUS_WIDTH  = 8;
`ifdef DATA_SYNC_GLITCH_FILTER_EN
    localparam int LAT = NUM_STAGES + 1;
`else
    localparam int LAT = NUM_STAGES;
`endif

    logic                 CLK;
    logic                 RST;
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_EN;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;

    int tests;
    int fails;

    data_sync #(
        .NUM_STAGES (NUM_STAGES),
        .BUS_WIDTH  (BUS_WIDTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .UNSYNC_BUS   (UNSYNC_BUS),
        .BUS_EN       (BUS_EN),
        .SYNC_BUS     (SYNC_BUS),
        .ENABLE_PULSE (ENABLE_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] bus;
        logic [7:0] exp_bus;
        logic       exp_pulse;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic [7:0] bus,
                       input logic [7:0] exp_bus, input logic exp_pulse, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.bus = bus;
        v.exp_bus = exp_bus; v.exp_pulse = exp_pulse; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive BUS_EN high for 'high' edges within a 'total'-edge window and count pulses.
    task automatic run_burst(input string name, input int high, input int total,
                             input logic [7:0] bus, input int exp_cnt);
        int cnt;
        int first;
        cnt = 0;
        first = 0;
        BUS_EN = 1'b0;
        repeat (4) tick();
        UNSYNC_BUS = bus;
        for (int i = 1; i <= total; i++) begin
            BUS_EN = (i <= high);
            tick();
            if (ENABLE_PULSE === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        BUS_EN = 1'b0;
        check({name, "_count"}, cnt, exp_cnt);
        if (exp_cnt > 0) begin
            check({name, "_latency"}, first, 1 + LAT);
            check({name, "_bus"}, {24'h0, SYNC_BUS}, {24'h0, bus});
        end
    endtask

    initial begin
        int seen;
        int idx;
        tests = 0;
        fails = 0;
        RST = 1'b1;
        BUS_EN = 1'b0;
        UNSYNC_BUS = 8'hFF;

        // Reset then idle
        add(1, 0, 8'hFF, 8'h00, 0, "rst0");
        add(1, 0, 8'hFF, 8'h00, 0, "rst1");
        add(1, 0, 8'hFF, 8'h00, 0, "rst2");
        add(0, 0, 8'hFF, 8'h00, 0, "idle0");
        add(0, 0, 8'hFF, 8'h00, 0, "idle1");
        // Single transfer: edge k samples BUS_EN high
        add(0, 1, 8'hA5, 8'h00, 0, "xfer1_k");
        add(0, 1, 8'hA5, 8'h00, 0, "xfer1_k1");
`ifdef DATA_SYNC_GLITCH_FILTER_EN
        add(0, 1, 8'hA5, 8'h00, 0, "xfer1_filt");
`endif
        add(0, 1, 8'hA5, 8'hA5, 1, "xfer1_pulse");
        add(0, 1, 8'hA5, 8'hA5, 0, "xfer1_after");
        add(0, 1, 8'h11, 8'hA5, 0, "xfer1_hold");
        // Re-arm: four low cycles, then second transfer
        add(0, 0, 8'h11, 8'hA5, 0, "low0");
        add(0, 0, 8'h11, 8'hA5, 0, "low1");
        add(0, 0, 8'h11, 8'hA5, 0, "low2");
        add(0, 0, 8'h3C, 8'hA5, 0, "low3");
        add(0, 1, 8'h3C, 8'hA5, 0, "xfer2_k");
        add(0, 1, 8'h3C, 8'hA5, 0, "xfer2_k1");
`ifdef DATA_SYNC_GLITCH_FILTER_EN
        add(0, 1, 8'h3C, 8'hA5, 0, "xfer2_filt");
`endif
        add(0, 1, 8'h3C, 8'h3C, 1, "xfer2_pulse");
        add(0, 1, 8'h3C, 8'h3C, 0, "xfer2_after");

        #1;
        foreach (vecs[i]) begin
            RST = vecs[i].rst;
            BUS_EN = vecs[i].en;
            UNSYNC_BUS = vecs[i].bus;
            tick();
            check({vecs[i].name, "_bus"}, {24'h0, SYNC_BUS}, {24'h0, vecs[i].exp_bus});
            check({vecs[i].name, "_pulse"}, {31'h0, ENABLE_PULSE}, {31'h0, vecs[i].exp_pulse});
        end

        // Level hold: 20 high cycles give exactly one pulse
        run_burst("level_hold", 20, 30, 8'hC3, 1);

        // Reset mid-transfer
        BUS_EN = 1'b0;
        UNSYNC_BUS = 8'h5A;
        repeat (4) tick();
        BUS_EN = 1'b1;
        tick();
        tick();
        #2 RST = 1'b1;
        #1;
        check("midrst_bus", {24'h0, SYNC_BUS}, 32'h0);
        check("midrst_pulse", {31'h0, ENABLE_PULSE}, 32'h0);
        seen = 0;
        repeat (2) begin
            tick();
            if (ENABLE_PULSE === 1'b1) seen++;
        end
        check("midrst_nopulse", seen, 0);
        RST = 1'b0;
        idx = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ENABLE_PULSE === 1'b1 && idx == 0) idx = i;
        end
        check("midrst_release_latency", idx, 1 + LAT);
        check("midrst_release_bus", {24'h0, SYNC_BUS}, 32'h5A);

        // Hold: bus changes while BUS_EN stays high
        UNSYNC_BUS = 8'h11;
        seen = 0;
        repeat (5) begin
            tick();
            if (ENABLE_PULSE === 1'b1) seen++;
        end
        check("hold_bus", {24'h0, SYNC_BUS}, 32'h5A);
        check("hold_nopulse", seen, 0);

        // One-cycle BUS_EN high: filtered build rejects it, default build passes one pulse
`ifdef DATA_SYNC_GLITCH_FILTER_EN
        run_burst("glitch1", 1, 12, 8'h77, 0);
`else
        run_burst("glitch1", 1, 12, 8'h77, 1);
`endif
        run_burst("burst3", 3, 12, 8'h96, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
